drift_apply_scheduler: RTL and testbench
========================================

DRIFT_APPLY_SCHEDULER -- requirements
Module: drift_apply_scheduler

Interface
REQ-001 SHALL have parameter OFFSET_WIDTH, default 8, width of the signed net-offset accumulators.
REQ-002 SHALL have parameter LOCKOUT_WIDTH, default clks_alot_p::RATE_COUNTER_WIDTH, width of the lockout counters.
REQ-003 SHALL have port clk_i, input, 1, single clock; all logic is on its rising edge.
REQ-004 SHALL have port async_rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port sched_en_i, input, 1; when low, no new request is armed.
REQ-006 SHALL have port clear_state_i, input, 1, synchronous clear of all state.
REQ-007 SHALL have port lockout_cycles_i, input, LOCKOUT_WIDTH, minimum idle cycles after each applied drift, per domain.
REQ-008 SHALL have ports exp_drift_req_i / pre_drift_req_i, input, 1 each, level requests from drift tracking for the expected and preemptive domains.
REQ-009 SHALL have ports exp_drift_dir_i / pre_drift_dir_i, input, 1 each; 1 = positive (late), 0 = negative (early).
REQ-010 SHALL have ports exp_drift_res_o / pre_drift_res_o, output, 1 each, one-cycle completion pulses.
REQ-011 SHALL have ports exp_boundary_i / pre_boundary_i, input, 1 each, one-cycle strobe at each generated edge of that domain.
REQ-012 SHALL have shared limit-adjust port outputs: adj_valid_o (1), adj_sel_o (1; 0 = expected, 1 = preemptive) and adj_dir_o (1).
REQ-013 SHALL have ports exp_net_offset_o / pre_net_offset_o, output, OFFSET_WIDTH signed each, plus offset_sat_o, output, 2 ({pre,exp}), sticky saturation flags.

Function
REQ-014 SHALL run one FSM per domain with states IDLE, ARMED, APPLY and LOCKOUT.
REQ-015 SHALL transition IDLE->ARMED when req is high and sched_en_i is high, capturing dir at that cycle.
REQ-016 SHALL transition ARMED->APPLY on a cycle where that domain's boundary strobe is high and the domain wins the shared port.
REQ-017 SHALL transition ARMED->IDLE with no res pulse and no adjust if req drops while ARMED (cancel).
REQ-018 SHALL, in APPLY (exactly 1 cycle), drive adj_valid_o=1, adj_sel_o=domain and adj_dir_o=captured dir, and pulse that domain's res_o; both are registered, appearing the cycle after the winning boundary.
REQ-019 SHALL transition APPLY->LOCKOUT, loading lockout_cycles_i; if the value is 0, it SHALL transition APPLY->IDLE directly.
REQ-020 SHALL hold LOCKOUT for exactly lockout_cycles_i cycles, then go to IDLE; req is ignored during LOCKOUT.
REQ-021 SHALL arbitrate with a single round-robin pointer when both domains are ARMED with boundaries in the same cycle; the winner applies, the pointer flips to the loser, and the loser stays ARMED for its next boundary.
REQ-022 SHALL give expected priority over preemptive after reset/clear (pointer = expected).
REQ-023 SHALL never assert adj_valid_o for both domains in one cycle; adj_valid_o=0 implies adj_sel_o=0 and adj_dir_o=0.
REQ-024 SHALL hold ARMED when sched_en_i goes low (no cancel); only IDLE->ARMED is gated.
REQ-025 SHALL, on clear_state_i, force both FSMs to IDLE, zero all counters/offsets/flags and suppress any pending res/adj on the next cycle.
REQ-026 SHALL treat a req still high on the IDLE cycle after LOCKOUT as a new request.

Reset
REQ-027 SHALL, on async_rst_i, immediately put both FSMs in IDLE, set the pointer to expected, zero lockout counters, offsets and offset_sat_o, and drive all res/adj outputs to 0.
REQ-028 SHALL discard any in-flight ARMED or APPLY state when reset asserts mid-operation; no res pulse follows reset release.

Configuration
REQ-029 SHALL support macro DRIFT_SCHED_NET_OFFSET_EN: when defined, each APPLY adds +1 (dir=1) or -1 (dir=0) to that domain's signed net offset, saturating at max/min; a saturated step sets the sticky offset_sat_o bit, and the adjust and res are still issued.
REQ-030 SHALL, without DRIFT_SCHED_NET_OFFSET_EN, tie net offsets and offset_sat_o to 0 and include no accumulator logic; all other behaviour is unchanged.

Verification
REQ-031 SHALL cover: exp req=1 dir=1, lockout=3, exp boundary 5 cycles later -> adj_valid=1 sel=0 dir=1 and exp res pulse at boundary+1, then IDLE 3 cycles after APPLY.
REQ-032 SHALL cover: both ARMED, both boundaries same cycle after reset -> expected applies first; preemptive applies at its next boundary; repeated collision -> preemptive wins.
REQ-033 SHALL cover: exp ARMED, req dropped before boundary -> no adj_valid, no res, FSM IDLE.
REQ-034 SHALL cover: lockout=0, req held high, boundary every 4 cycles -> one apply per boundary, res every 4 cycles.
REQ-035 SHALL cover: async_rst_i asserted in APPLY cycle -> res/adj low immediately, no pulse after release.
REQ-036 SHALL cover, with macro: OFFSET_WIDTH=4, 8 positive applies on pre -> offset 7, pre sat bit=1, adj still issued on the 8th.

Source files
------------

// File: rtl/drift_apply_scheduler.sv
// Drift apply scheduler: two per-domain FSMs (expected / preemptive) that arm on
// a drift request, apply one limit adjust at the next domain boundary through a
// shared round-robin-arbitrated port, then sit out a programmable lockout.
// Optional feature macro: DRIFT_SCHED_NET_OFFSET_EN (signed net-offset accumulators).

package clks_alot_p;
    localparam int RATE_COUNTER_WIDTH = 8;
endpackage

module drift_apply_scheduler #(
    parameter int OFFSET_WIDTH  = 8,
    parameter int LOCKOUT_WIDTH = clks_alot_p::RATE_COUNTER_WIDTH
) (
    input  logic                           clk_i,
    input  logic                           async_rst_i,
    input  logic                           sched_en_i,
    input  logic                           clear_state_i,
    input  logic [LOCKOUT_WIDTH-1:0]       lockout_cycles_i,
    input  logic                           exp_drift_req_i,
    input  logic                           pre_drift_req_i,
    input  logic                           exp_drift_dir_i,
    input  logic                           pre_drift_dir_i,
    output logic                           exp_drift_res_o,
    output logic                           pre_drift_res_o,
    input  logic                           exp_boundary_i,
    input  logic                           pre_boundary_i,
    output logic                           adj_valid_o,
    output logic                           adj_sel_o,
    output logic                           adj_dir_o,
    output logic signed [OFFSET_WIDTH-1:0] exp_net_offset_o,
    output logic signed [OFFSET_WIDTH-1:0] pre_net_offset_o,
    output logic [1:0]                     offset_sat_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        APPLY   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam logic [LOCKOUT_WIDTH-1:0] LOCK_ONE = LOCKOUT_WIDTH'(1);

    // Index 0 is the expected domain, index 1 the preemptive domain.
    state_t                   state_q [2];
    state_t                   state_d [2];
    logic [LOCKOUT_WIDTH-1:0] cnt_q   [2];
    logic [LOCKOUT_WIDTH-1:0] cnt_d   [2];
    logic [1:0]               dir_q;
    logic [1:0]               dir_d;
    logic                     ptr_q;
    logic                     ptr_d;

    logic [1:0] req;
    logic [1:0] dir_in;
    logic [1:0] bnd;
    logic [1:0] elig;
    logic [1:0] win;

    assign req    = {pre_drift_req_i, exp_drift_req_i};
    assign dir_in = {pre_drift_dir_i, exp_drift_dir_i};
    assign bnd    = {pre_boundary_i, exp_boundary_i};

    // A domain competes when armed, still requesting, and at its boundary; the
    // pointer only breaks ties and only moves when a tie actually happens.
    always_comb begin
        elig    = 2'b00;
        win     = 2'b00;
        elig[0] = (state_q[0] == ARMED) && req[0] && bnd[0];
        elig[1] = (state_q[1] == ARMED) && req[1] && bnd[1];
        win[0]  = elig[0] && (!elig[1] || !ptr_q);
        win[1]  = elig[1] && (!elig[0] || ptr_q);
    end

    // Next-state logic for both domain FSMs and the round-robin pointer.
    always_comb begin
        ptr_d = ptr_q;
        dir_d = dir_q;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
        end
        if (elig == 2'b11) begin
            ptr_d = win[0];
        end
        for (int i = 0; i < 2; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (req[i] && sched_en_i) begin
                        state_d[i] = ARMED;
                        dir_d[i]   = dir_in[i];
                    end
                end
                ARMED: begin
                    if (!req[i]) begin
                        state_d[i] = IDLE;
                    end else if (win[i]) begin
                        state_d[i] = APPLY;
                    end
                end
                APPLY: begin
                    if (lockout_cycles_i == '0) begin
                        state_d[i] = IDLE;
                    end else begin
                        state_d[i] = LOCKOUT;
                        cnt_d[i]   = lockout_cycles_i;
                    end
                end
                LOCKOUT: begin
                    if (cnt_q[i] <= LOCK_ONE) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] - LOCK_ONE;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
        if (clear_state_i) begin
            ptr_d = 1'b0;
            dir_d = 2'b00;
            for (int i = 0; i < 2; i++) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end
        end
    end

    // State register; reset drops any in-flight request and restores expected priority.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q[0] <= IDLE;
            state_q[1] <= IDLE;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            dir_q      <= 2'b00;
            ptr_q      <= 1'b0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            dir_q      <= dir_d;
            ptr_q      <= ptr_d;
        end
    end

    // The APPLY state is the registered adjust/result; arbitration guarantees at most one domain is in it.
    always_comb begin
        exp_drift_res_o = (state_q[0] == APPLY);
        pre_drift_res_o = (state_q[1] == APPLY);
        adj_valid_o     = exp_drift_res_o || pre_drift_res_o;
        adj_sel_o       = pre_drift_res_o && !exp_drift_res_o;
        adj_dir_o       = 1'b0;
        if (exp_drift_res_o) begin
            adj_dir_o = dir_q[0];
        end else if (pre_drift_res_o) begin
            adj_dir_o = dir_q[1];
        end
    end

`ifdef DRIFT_SCHED_NET_OFFSET_EN
    localparam logic signed [OFFSET_WIDTH-1:0] OFF_MAX = {1'b0, {(OFFSET_WIDTH-1){1'b1}}};
    localparam logic signed [OFFSET_WIDTH-1:0] OFF_MIN = {1'b1, {(OFFSET_WIDTH-1){1'b0}}};
    localparam logic signed [OFFSET_WIDTH-1:0] OFF_ONE = OFFSET_WIDTH'(1);

    logic signed [OFFSET_WIDTH-1:0] offset_q [2];
    logic [1:0]                     sat_q;

    // Net offsets step with each winning boundary; a clipped step latches the sticky flag.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            offset_q[0] <= '0;
            offset_q[1] <= '0;
            sat_q       <= 2'b00;
        end else if (clear_state_i) begin
            offset_q[0] <= '0;
            offset_q[1] <= '0;
            sat_q       <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (win[i]) begin
                    if (dir_q[i]) begin
                        if (offset_q[i] == OFF_MAX) begin
                            sat_q[i] <= 1'b1;
                        end else begin
                            offset_q[i] <= offset_q[i] + OFF_ONE;
                        end
                    end else begin
                        if (offset_q[i] == OFF_MIN) begin
                            sat_q[i] <= 1'b1;
                        end else begin
                            offset_q[i] <= offset_q[i] - OFF_ONE;
                        end
                    end
                end
            end
        end
    end

    assign exp_net_offset_o = offset_q[0];
    assign pre_net_offset_o = offset_q[1];
    assign offset_sat_o     = sat_q;
`else
    assign exp_net_offset_o = '0;
    assign pre_net_offset_o = '0;
    assign offset_sat_o     = 2'b00;
`endif

endmodule

// File: tb/tb_drift_apply_scheduler.sv
// Directed self-checking bench for drift_apply_scheduler.
// Outputs are packed as {adj_valid, adj_sel, adj_dir, exp_res, pre_res} for compact checks.
module tb_drift_apply_scheduler;

    localparam int OW = 4;
    localparam int LW = 8;

    localparam logic [31:0] S_IDLE    = 32'd0;
    localparam logic [31:0] S_ARMED   = 32'd1;
    localparam logic [31:0] S_LOCKOUT = 32'd3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sched_en;
    logic                 clear_state;
    logic [LW-1:0]        lockout_cycles;
    logic                 exp_req, pre_req, exp_dir, pre_dir;
    logic                 exp_res, pre_res;
    logic                 exp_bnd, pre_bnd;
    logic                 adj_valid, adj_sel, adj_dir;
    logic signed [OW-1:0] exp_off, pre_off;
    logic [1:0]           off_sat;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    drift_apply_scheduler #(.OFFSET_WIDTH(OW), .LOCKOUT_WIDTH(LW)) dut (
        .clk_i            (clk),
        .async_rst_i      (rst),
        .sched_en_i       (sched_en),
        .clear_state_i    (clear_state),
        .lockout_cycles_i (lockout_cycles),
        .exp_drift_req_i  (exp_req),
        .pre_drift_req_i  (pre_req),
        .exp_drift_dir_i  (exp_dir),
        .pre_drift_dir_i  (pre_dir),
        .exp_drift_res_o  (exp_res),
        .pre_drift_res_o  (pre_res),
        .exp_boundary_i   (exp_bnd),
        .pre_boundary_i   (pre_bnd),
        .adj_valid_o      (adj_valid),
        .adj_sel_o        (adj_sel),
        .adj_dir_o        (adj_dir),
        .exp_net_offset_o (exp_off),
        .pre_net_offset_o (pre_off),
        .offset_sat_o     (off_sat)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, then advance past the next rising edge.
    task automatic applyStimulus(input logic en, input logic er, input logic ed, input logic eb,
                                 input logic pr, input logic pd, input logic pb);
        sched_en = en;
        exp_req  = er;
        exp_dir  = ed;
        exp_bnd  = eb;
        pre_req  = pr;
        pre_dir  = pd;
        pre_bnd  = pb;
        cyc(1);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {27'd0, adj_valid, adj_sel, adj_dir, exp_res, pre_res};
    endfunction

    function automatic logic [31:0] exp_state();
        return 32'(dut.state_q[0]);
    endfunction

    task automatic applyReset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        rst            = 1'b1;
        clear_state    = 1'b0;
        lockout_cycles = '0;
        sched_en       = 1'b0;
        exp_req = 1'b0; exp_dir = 1'b0; exp_bnd = 1'b0;
        pre_req = 1'b0; pre_dir = 1'b0; pre_bnd = 1'b0;
        cyc(2);
        checkOutput("reset_outs", outs(), 32'h00);
        checkOutput("reset_offsets", {22'd0, off_sat, exp_off, pre_off}, 32'h0);
        rst = 1'b0;
        cyc(1);

        // Single expected apply with lockout of 3
        lockout_cycles = 8'd3;
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        checkOutput("t1_armed_state", exp_state(), S_ARMED);
        checkOutput("t1_armed_outs", outs(), 32'h00);
        repeat (4) applyStimulus(1, 1, 1, 0, 0, 0, 0);
        checkOutput("t1_wait_outs", outs(), 32'h00);
        applyStimulus(1, 1, 1, 1, 0, 0, 0);
        checkOutput("t1_apply", outs(), 32'h16);
        applyStimulus(1, 1, 1, 1, 0, 0, 0);
        checkOutput("t1_lock1_outs", outs(), 32'h00);
        checkOutput("t1_lock1_state", exp_state(), S_LOCKOUT);
        applyStimulus(1, 1, 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 0, 0, 0);
        checkOutput("t1_lock3_state", exp_state(), S_LOCKOUT);
        checkOutput("t1_lock3_outs", outs(), 32'h00);
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        checkOutput("t1_idle_state", exp_state(), S_IDLE);
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        checkOutput("t1_rearm_state", exp_state(), S_ARMED);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_cancel_state", exp_state(), S_IDLE);

        // Synchronous clear on the winning boundary suppresses the apply
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        clear_state = 1'b1;
        applyStimulus(1, 1, 0, 1, 0, 0, 0);
        clear_state = 1'b0;
        checkOutput("clr_outs", outs(), 32'h00);
        checkOutput("clr_state", exp_state(), S_IDLE);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

        // Collisions and round-robin pointer
        applyReset();
        lockout_cycles = 8'd0;
        applyStimulus(1, 1, 0, 0, 1, 1, 0);
        applyStimulus(1, 1, 0, 1, 1, 1, 1);
        checkOutput("rr_first_exp", outs(), 32'h12);
        applyStimulus(1, 1, 0, 0, 1, 1, 0);
        checkOutput("rr_gap_outs", outs(), 32'h00);
        applyStimulus(1, 1, 0, 0, 1, 1, 0);
        applyStimulus(1, 1, 0, 0, 1, 1, 1);
        checkOutput("rr_pre_next", outs(), 32'h1D);
        applyStimulus(1, 1, 0, 0, 1, 1, 0);
        applyStimulus(1, 1, 0, 0, 1, 1, 0);
        applyStimulus(1, 1, 0, 1, 1, 1, 1);
        checkOutput("rr_second_pre", outs(), 32'h1D);
        applyStimulus(1, 1, 0, 0, 1, 1, 0);
        checkOutput("rr_exp_waiting", exp_state(), S_ARMED);
        applyStimulus(1, 1, 0, 1, 1, 1, 0);
        checkOutput("rr_exp_later", outs(), 32'h12);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

        // Cancel while armed
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        checkOutput("cancel_state", exp_state(), S_IDLE);
        applyStimulus(1, 0, 1, 1, 0, 0, 0);
        checkOutput("cancel_outs", outs(), 32'h00);

        // Disable holds ARMED but blocks new arming
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("dis_hold_state", exp_state(), S_ARMED);
        applyStimulus(0, 1, 1, 1, 0, 0, 0);
        checkOutput("dis_apply", outs(), 32'h16);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("dis_no_arm", exp_state(), S_IDLE);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

        // Zero lockout with periodic boundaries
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 1, 0, (i % 4) == 0, 0, 0, 0);
            checkOutput($sformatf("periodic_%0d", i), {31'd0, exp_res}, ((i % 4) == 0) ? 32'd1 : 32'd0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

`ifndef DRIFT_SCHED_NET_OFFSET_EN
        checkOutput("off_tied_zero", {22'd0, off_sat, exp_off, pre_off}, 32'h0);
`endif

        // Asynchronous reset during APPLY
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 0, 0, 0);
        checkOutput("arst_pre_apply", outs(), 32'h16);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_immediate", outs(), 32'h00);
        cyc(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 1, 0, 0, 0, 0);
            checkOutput($sformatf("arst_after_%0d", i), outs(), 32'h00);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

`ifdef DRIFT_SCHED_NET_OFFSET_EN
        // Positive saturation on the preemptive net offset
        applyReset();
        lockout_cycles = 8'd0;
        applyStimulus(1, 0, 0, 0, 1, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1, 0, 0, 0, 1, 1, 1);
            checkOutput($sformatf("sat_adj_%0d", k), outs(), 32'h1D);
            checkOutput($sformatf("sat_off_%0d", k), {28'd0, pre_off}, (k > 7) ? 32'd7 : 32'(k));
            checkOutput($sformatf("sat_flag_%0d", k), {30'd0, off_sat}, (k == 8) ? 32'd2 : 32'd0);
            applyStimulus(1, 0, 0, 0, 1, 1, 0);
            applyStimulus(1, 0, 0, 0, 1, 1, 0);
        end
        checkOutput("sat_exp_off", {28'd0, exp_off}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
